addr_mode_tracer: RTL and testbench



---
 rtl/addr_mode_tracer.sv | 231 +++++++++++++++++++++++
 tb/tb_addr_mode_tracer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/addr_mode_tracer.sv
// addr_mode_tracer: samples the 6502 decoder's one-hot addressing-mode strobes,
// keeps saturating per-mode / unknown / drop counters, and buffers trace
// entries {multi, unknown, idx[3:0], opcode} in a FIFO drained over valid/ready.
// Optional simulation trace printing is compiled in only when the macro
// ADDR_MODE_TRACE_DISPLAY_EN is defined; hardware behaviour is identical.
module addr_mode_tracer #(
    parameter int NUM_MODES = 13,
    parameter int INSN_W    = 8,
    parameter int DEPTH     = 8,
    parameter int COUNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [NUM_MODES-1:0]  mode,
    input  logic [INSN_W-1:0]     instruction,
    input  logic                  trace_en,
    input  logic                  clr_cnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSN_W+5:0]     out_data,
    input  logic [3:0]            cnt_sel,
    output logic [COUNT_W-1:0]    cnt_data,
    output logic                  err_multi,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = INSN_W + 6;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    // Decoded view of the current sample
    logic [3:0]           idx;
    logic                 unknown;
    logic                 multi;
    logic [NUM_MODES-1:0] mode_minus_one;
    logic [EW-1:0]        entry;

    // Statistics state
    logic [COUNT_W-1:0] mode_cnt_q [NUM_MODES];
    logic [COUNT_W-1:0] mode_cnt_d [NUM_MODES];
    logic [COUNT_W-1:0] unk_cnt_q, unk_cnt_d;
    logic [COUNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic               err_multi_q, err_multi_d;
    logic [COUNT_W-1:0] cnt_data_q, cnt_data_d;

    // FIFO state
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic drop;
    logic push_ok;

    // Clearing the lowest set bit leaves something behind only for multi-hot input
    assign mode_minus_one = mode - NUM_MODES'(1);
    assign multi          = |(mode & mode_minus_one);

    // Priority-encode the lowest set mode bit; no bit set means unknown / 4'hF
    always_comb begin
        idx     = 4'hF;
        unknown = 1'b1;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (mode[i]) begin
                idx     = 4'(i);
                unknown = 1'b0;
            end
        end
    end

    assign entry = {multi, unknown, idx, instruction};

    // FIFO flags and handshake qualification; a full FIFO can still accept a push
    // when the head leaves in the same cycle
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push       = in_valid && trace_en;
        pop        = !fifo_empty && out_ready;
        drop       = push && fifo_full && !pop;
        push_ok    = push && !drop;
    end

    // FIFO storage and pointer next-state
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = entry;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Saturating counters and sticky multi flag; a clear overrides any sample
    always_comb begin
        unk_cnt_d   = unk_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        err_multi_d = err_multi_q;
        for (int i = 0; i < NUM_MODES; i++) begin
            mode_cnt_d[i] = mode_cnt_q[i];
        end
        if (clr_cnt) begin
            unk_cnt_d   = '0;
            drop_cnt_d  = '0;
            err_multi_d = 1'b0;
            for (int i = 0; i < NUM_MODES; i++) begin
                mode_cnt_d[i] = '0;
            end
        end else begin
            if (in_valid) begin
                if (unknown) begin
                    if (unk_cnt_q != CNT_MAX) begin
                        unk_cnt_d = unk_cnt_q + COUNT_W'(1);
                    end
                end else begin
                    for (int i = 0; i < NUM_MODES; i++) begin
                        if ((idx == 4'(i)) && (mode_cnt_q[i] != CNT_MAX)) begin
                            mode_cnt_d[i] = mode_cnt_q[i] + COUNT_W'(1);
                        end
                    end
                end
                if (multi) begin
                    err_multi_d = 1'b1;
                end
            end
            if (drop && (drop_cnt_q != CNT_MAX)) begin
                drop_cnt_d = drop_cnt_q + COUNT_W'(1);
            end
        end
    end

    // Counter read mux; registered so cnt_data lags the counters by one edge
    always_comb begin
        cnt_data_d = '0;
        if (cnt_sel == 4'd14) begin
            cnt_data_d = drop_cnt_q;
        end else if (cnt_sel == 4'd15) begin
            cnt_data_d = unk_cnt_q;
        end else begin
            for (int i = 0; i < NUM_MODES; i++) begin
                if (cnt_sel == 4'(i)) begin
                    cnt_data_d = mode_cnt_q[i];
                end
            end
        end
    end

    // State registers; reset wipes counters, pointers and FIFO contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unk_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            err_multi_q <= 1'b0;
            cnt_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < NUM_MODES; i++) begin
                mode_cnt_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            unk_cnt_q   <= unk_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_multi_q <= err_multi_d;
            cnt_data_q  <= cnt_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            for (int i = 0; i < NUM_MODES; i++) begin
                mode_cnt_q[i] <= mode_cnt_d[i];
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_valid = !fifo_empty;
    assign full      = fifo_full;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign cnt_data  = cnt_data_q;
    assign err_multi = err_multi_q;

`ifdef ADDR_MODE_TRACE_DISPLAY_EN
    function automatic string mode_name(input logic [3:0] i);
        case (i)
            4'd0:    return "immediate";
            4'd1:    return "absolute";
            4'd2:    return "zpg_absolute";
            4'd3:    return "implied";
            4'd4:    return "accumulator";
            4'd5:    return "abs_indexed_x";
            4'd6:    return "abs_indexed_y";
            4'd7:    return "zpg_indexed_x";
            4'd8:    return "zpg_indexed_y";
            4'd9:    return "indirect";
            4'd10:   return "indirect_x";
            4'd11:   return "indirect_y";
            4'd12:   return "relative";
            default: return "unknown";
        endcase
    endfunction

    // Human-readable trace of every sampled decode
    always @(posedge clk) begin
        if (rst_n && in_valid) begin
            $display("addr_mode_tracer: %s opcode=%h", unknown ? "unknown" : mode_name(idx), instruction);
            if (multi) begin
                $display("addr_mode_tracer: warning multi mode=%h", mode);
            end
            if (drop) begin
                $display("addr_mode_tracer: warning drop opcode=%h", instruction);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_addr_mode_tracer.sv
// tb_addr_mode_tracer: directed plus randomized bench for addr_mode_tracer,
// checked every cycle against a queue-and-integer reference model.
module tb_addr_mode_tracer;

    localparam int NM  = 13;
    localparam int IW  = 8;
    localparam int DEP = 8;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [NM-1:0]     mode;
    logic [IW-1:0]     instruction;
    logic              trace_en;
    logic              clr_cnt;
    logic              out_valid;
    logic              out_ready;
    logic [IW+5:0]     out_data;
    logic [3:0]        cnt_sel;
    logic [CW-1:0]     cnt_data;
    logic              err_multi;
    logic              full;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_cnt [16];
    int          m_unk;
    int          m_drop;
    bit          m_err;
    int          m_cnt_data;
    logic [13:0] m_q [$];

    addr_mode_tracer #(
        .NUM_MODES(NM), .INSN_W(IW), .DEPTH(DEP), .COUNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
        .instruction(instruction), .trace_en(trace_en), .clr_cnt(clr_cnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cnt_sel(cnt_sel), .cnt_data(cnt_data), .err_multi(err_multi), .full(full)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int satInc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    function automatic int selModel(input logic [3:0] sel);
        if (sel < NM)  return m_cnt[sel];
        if (sel == 14) return m_drop;
        if (sel == 15) return m_unk;
        return 0;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_unk = 0;
        m_drop = 0;
        m_err = 0;
        m_cnt_data = 0;
        m_q.delete();
    endtask

    // Compare every observable output against the model
    task automatic checkOutput();
        checkVal("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        checkVal("full", 32'(full), 32'(m_q.size() == DEP));
        checkVal("err_multi", 32'(err_multi), 32'(m_err));
        checkVal("cnt_data", 32'(cnt_data), 32'(m_cnt_data));
        if (m_q.size() != 0) checkVal("out_data", 32'(out_data), 32'(m_q[0]));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check
    task automatic applyStimulus(input bit v, input logic [NM-1:0] md, input logic [IW-1:0] ins,
                                 input bit te, input bit clr, input bit rdy, input logic [3:0] sel);
        int    low;
        bit    unk;
        bit    mul;
        bit    do_pop;
        bit    do_push;
        bit    dropped;
        logic [13:0] e;
        in_valid = v; mode = md; instruction = ins; trace_en = te;
        clr_cnt = clr; out_ready = rdy; cnt_sel = sel;
        low = 15;
        for (int j = NM - 1; j >= 0; j--) if (md[j]) low = j;
        unk = (md == 0);
        mul = ($countones(md) > 1);
        e = {mul, unk, 4'(low), ins};
        do_pop  = (m_q.size() != 0) && rdy;
        do_push = v && te;
        dropped = do_push && (m_q.size() == DEP) && !do_pop;
        m_cnt_data = selModel(sel);
        @(posedge clk);
        #1;
        if (do_pop) void'(m_q.pop_front());
        if (do_push && !dropped) m_q.push_back(e);
        if (clr) begin
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_unk = 0; m_drop = 0; m_err = 0;
        end else begin
            if (v) begin
                if (unk) m_unk = satInc(m_unk);
                else m_cnt[low] = satInc(m_cnt[low]);
                if (mul) m_err = 1;
            end
            if (dropped) m_drop = satInc(m_drop);
        end
        checkOutput();
    endtask

    task automatic idle(input bit rdy, input logic [3:0] sel);
        applyStimulus(0, '0, '0, 0, 0, rdy, sel);
    endtask

    function automatic logic [NM-1:0] randMode();
        int r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return NM'($urandom);
        return NM'(1) << $urandom_range(0, NM - 1);
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 0; mode = '0; instruction = '0;
        trace_en = 0; clr_cnt = 0; out_ready = 0; cnt_sel = '0;
        modelReset();
        #2;
        checkVal("reset_out_valid", 32'(out_valid), 0);
        checkVal("reset_out_data", 32'(out_data), 0);
        checkVal("reset_cnt_data", 32'(cnt_data), 0);
        checkVal("reset_full", 32'(full), 0);
        checkVal("reset_err_multi", 32'(err_multi), 0);
        @(posedge clk); @(posedge clk); #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput();

        // Single immediate sample
        applyStimulus(1, 13'h0001, 8'hA9, 1, 0, 0, 4'd0);
        checkVal("first_entry", 32'(out_data), 32'h00A9);
        idle(0, 4'd0);
        checkVal("imm_count", 32'(cnt_data), 1);
        idle(1, 4'd0);

        // Unknown sample
        applyStimulus(1, 13'h0000, 8'hFF, 1, 0, 0, 4'd15);
        checkVal("unknown_entry", 32'(out_data), 32'h1FFF);
        idle(0, 4'd15);
        checkVal("unk_count", 32'(cnt_data), 1);
        idle(1, 4'd15);

        // Multi-hot sample, sticky flag, clear wins over a same-cycle sample
        applyStimulus(1, 13'h0006, 8'h10, 1, 0, 1, 4'd1);
        checkVal("multi_entry", 32'(out_data), 32'h2110);
        checkVal("multi_sticky", 32'(err_multi), 1);
        for (int i = 0; i < 3; i++) idle(1, 4'd1);
        applyStimulus(1, 13'h0001, 8'h20, 1, 1, 1, 4'd0);
        idle(1, 4'd0);
        checkVal("clear_wins", 32'(cnt_data), 0);
        checkVal("clear_err", 32'(err_multi), 0);
        idle(1, 4'd0);

        // Overflow: 10 pushes into an 8-deep FIFO drop two
        for (int i = 0; i < 10; i++) applyStimulus(1, 13'h0001, 8'(8'h30 + i), 1, 0, 0, 4'd14);
        checkVal("full_flag", 32'(full), 1);
        idle(0, 4'd14);
        checkVal("drop_count", 32'(cnt_data), 2);
        for (int k = 0; k < 8; k++) begin
            checkVal("drain_order", 32'(out_data[7:0]), 32'(8'h30 + k));
            idle(1, 4'd14);
        end

        // Full FIFO with simultaneous push/pop for 20 cycles
        for (int i = 0; i < 8; i++) applyStimulus(1, 13'h0002, 8'(8'h40 + i), 1, 0, 0, 4'd14);
        for (int i = 0; i < 20; i++) applyStimulus(1, 13'h0002, 8'(8'h50 + i), 1, 0, 1, 4'd14);
        idle(0, 4'd14);
        checkVal("no_new_drops", 32'(cnt_data), 2);
        for (int k = 0; k < 8; k++) begin
            checkVal("wrap_order", 32'(out_data[7:0]), 32'(8'h5C + k));
            idle(1, 4'd14);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 4) != 0, randMode(), 8'($urandom),
                          $urandom_range(0, 4) != 0, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 1) == 1, 4'($urandom));
        end

        // Saturation of the immediate counter
        applyStimulus(0, '0, '0, 0, 1, 1, 4'd0);
        for (int i = 0; i < 17; i++) applyStimulus(1, 13'h0001, 8'hA9, 0, 0, 1, 4'd0);
        idle(1, 4'd0);
        checkVal("saturated", 32'(cnt_data), 32'h000F);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) applyStimulus(1, 13'h0046, 8'(8'h70 + i), 1, 0, 0, 4'd0);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkVal("midreset_out_valid", 32'(out_valid), 0);
        checkVal("midreset_out_data", 32'(out_data), 0);
        checkVal("midreset_cnt_data", 32'(cnt_data), 0);
        checkVal("midreset_err", 32'(err_multi), 0);
        checkVal("midreset_full", 32'(full), 0);
        in_valid = 0; trace_en = 0; out_ready = 0;
        @(posedge clk); #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput();
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randMode(), 8'($urandom),
                          1, 0, $urandom_range(0, 2) == 0, 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
